regfile_port_ctrl: RTL and testbench
====================================

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 SHALL have parameter WORD, 16, datapath width, taken from fmt.v `WORD.
REQ-002 SHALL have parameter REGISTERS, 8, register count; register codes are 3 bits.
REQ-003 SHALL have parameter SREG_IDX, 7, status-register index, equal to fmt.v `SREG.
REQ-004 SHALL have parameter WB_DEPTH, 2, number of writeback buffer entries.
REQ-005 SHALL have port clk, input, 1, the single clock; every register samples on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-007 SHALL have ports dec_valid/dec_ready (in/out, 1 each) and dec_reg1/dec_reg2 (in, 3 each): the operand fetch request.
REQ-008 SHALL have ports op_valid (out, 1), op_ready (in, 1) and op_val1/op_val2/op_sreg (out, WORD each): the operands delivered to execute.
REQ-009 SHALL have ports wb_valid/wb_ready (in/out, 1 each) and the writeback request fields:
- wb_code, in, 3
- wb_data, in, WORD
- wb_wr_reg, in, 1
- wb_wr_flag, in, 1
- wb_sreg, in, WORD
REQ-010 SHALL have register-file-side ports:
- get_reg_en, out, 1
- reg1, out, 3
- reg2, out, 3
- data_out1, in, WORD
- data_out2, in, WORD
- SREG_read, in, WORD
- reg_write_back, out, 1
- reg_write_code, out, 3
- data_in, out, WORD
- flag_update, out, 1
- SREG_write, out, WORD
- re, out, 1
- we, out, 1

Function
REQ-011 SHALL implement a fetch FSM with states IDLE, FETCH, CAPT and HOLD.
REQ-012 SHALL assert dec_ready only in IDLE with no hazard; a handshake latches dec_reg1/dec_reg2 and moves the FSM to FETCH.
REQ-013 In FETCH, get_reg_en and re SHALL be 1 for exactly one cycle, with reg1/reg2 driven from the latched codes; the FSM then moves to CAPT.
REQ-014 In CAPT, the block SHALL register data_out1, data_out2 and SREG_read into op_val1, op_val2 and op_sreg, then move to HOLD.
- Fetch-to-op_valid latency is 3 cycles from the dec handshake.
REQ-015 In HOLD, op_valid SHALL be 1 and the operands stable; op_ready=1 returns the FSM to IDLE.
- No back-to-back issue: dec_ready is 0 in the HOLD exit cycle.
REQ-016 A hazard SHALL exist when any valid writeback entry has:
- wb_wr_reg set and a code equal to dec_reg1 or dec_reg2, or
- wb_wr_flag set (SREG is always read).
REQ-017 While a hazard exists, the block SHALL hold dec_ready at 0.
REQ-018 The writeback buffer SHALL be a WB_DEPTH-entry FIFO.
- wb_ready = not full; push on wb_valid && wb_ready.
- An entry with both wb_wr_reg and wb_wr_flag at 0 SHALL be accepted and dropped, never stored.
REQ-019 When the FIFO is non-empty, the head entry SHALL drive the register file for one cycle and then pop; drain rate is one entry per cycle.
- reg_write_back = head.wr_reg, reg_write_code/data_in = head code/data.
- flag_update = head.wr_flag, SREG_write = head.sreg.
- we = reg_write_back OR flag_update.
REQ-020 Simultaneous push and pop SHALL both take effect, leaving the count unchanged; push when full SHALL be refused, with no bypass.
REQ-021 Pointers SHALL wrap modulo WB_DEPTH, and the count SHALL range 0..WB_DEPTH.
REQ-022 Drain SHALL proceed regardless of the fetch FSM state.
- A drain cycle coinciding with FETCH is legal only for non-hazard registers, which REQ-016/017 guarantee.
REQ-023 When not driven by a drain or fetch, every register-file-side output SHALL be 0.

Reset
REQ-024 While rst=1, the block SHALL:
- put the FSM in IDLE;
- empty the FIFO with pointers at 0;
- drive all outputs to 0, including op_val*, dec_ready and wb_ready.
REQ-025 On reset mid-operation, an in-flight fetch and any buffered writebacks SHALL be discarded; no get_reg_en, reg_write_back or flag_update pulse may follow the reset edge.
REQ-026 In the first cycle after rst deasserts, dec_ready and wb_ready SHALL be 1.

Structure
REQ-027 WORD, REGISTERS and SREG_IDX SHALL come from the shared fmt.v defines; the FSM state encoding and the writeback-entry field widths SHALL be defined there too.
REQ-028 The FIFO SHALL be a separate sub-module named wb_fifo, containing storage, pointers, count, full and empty; the FSM and hazard compare stay in the top module.

Verification
REQ-029 The bench SHALL cover an operand fetch:
- preload R2=0x0012, R5=0xFFF0, SREG=0x0001; request reg1=2, reg2=5;
- get_reg_en pulses once, 1 cycle after the handshake;
- op_valid rises 3 cycles after the handshake with 0x0012/0xFFF0/0x0001.
REQ-030 The bench SHALL cover a RAW hazard:
- push wb {code=3, data=0x00AA, wr_reg=1}, then request reg1=3 in the same cycle;
- dec_ready stays 0 until the drain cycle completes;
- op_val1 = 0x00AA.
REQ-031 The bench SHALL cover a flag hazard:
- push wb {wr_flag=1, sreg=0x0004}, then request any registers;
- the fetch stalls until flag_update pulses;
- op_sreg = 0x0004.
REQ-032 The bench SHALL cover FIFO full:
- hold op_ready=0 and push 2 writebacks to codes 1 and 2;
- the FIFO drains 1 per cycle;
- with the sink forced so wb_ready observed at 0 after 2 pushes, the third push is refused; pointer wrap is checked over 5 pushes.
REQ-033 The bench SHALL cover reset mid-operation:
- assert rst in the CAPT state with 1 entry buffered;
- op_valid=0 and no write pulses appear afterwards;
- dec_ready=1 in the cycle after release.
REQ-034 The bench SHALL cover a dropped entry: push wb {wr_reg=0, wr_flag=0} -> count stays 0 and we never asserts.

Source files
------------

// File: rtl/regfile_port_ctrl_pkg.sv
// Shared format definitions for the register-file port controller.
// Purpose : datapath width, register count, status-register index,
//           fetch FSM state encoding and writeback-entry field widths.
// Ports   : none (package).
package regfile_port_ctrl_pkg;

    localparam int FMT_WORD      = 16;  // datapath width
    localparam int FMT_REGISTERS = 8;   // register count
    localparam int FMT_SREG      = 7;   // status-register index
    localparam int FMT_CODE_W    = 3;   // register code width
    localparam int FMT_WB_FLAGS  = 2;   // wr_reg + wr_flag

    // Writeback entry layout, MSB first: {code, wr_reg, wr_flag, data, sreg}.
    // The tag (code + flags) sits at the top so the hazard compare can look
    // at just those bits of every buffered entry.
    localparam int FMT_WB_TAG_W  = FMT_CODE_W + FMT_WB_FLAGS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/regfile_port_ctrl_wb_fifo.sv
// Writeback buffer: small FIFO of pending register-file writes.
// Purpose : stores writeback entries, exposes the head for draining and the
//           tag bits of every slot with a per-slot valid for hazard checks.
// Ports   : clk, rst (async, active-high); push/push_data; pop; head;
//           slot_tags/slot_valid (all slots); full, empty.
module wb_fifo #(
    parameter int ENTRY_W = 37,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic [DEPTH*TAG_W-1:0]   slot_tags,
    output logic [DEPTH-1:0]         slot_valid,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Distance of a slot from the read pointer, modulo DEPTH; a slot holds
    // live data when this distance is below the occupancy count.
    function automatic logic [CNT_W-1:0] slot_dist(input int slot, input logic [PTR_W-1:0] rd);
        int d;
        d = slot - int'(rd);
        if (d < 0) d = d + DEPTH;
        return CNT_W'(d);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_tags[gi*TAG_W +: TAG_W] = mem_reg[gi][ENTRY_W-1 -: TAG_W];
        assign slot_valid[gi] = (slot_dist(gi, rd_ptr_reg) < count_reg);
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller.
// Purpose : fetches two operands plus SREG for execute through a
//           IDLE/FETCH/CAPT/HOLD FSM, buffers writebacks in a small FIFO that
//           drains one entry per cycle, and stalls fetches that would read a
//           register (or SREG) with a pending write.
// Ports   : clk, rst (async, active-high)
//           dec_*  : operand fetch request (valid/ready, two register codes)
//           op_*   : operands to execute (valid/ready, val1/val2/sreg)
//           wb_*   : writeback request (valid/ready, code/data/flags/sreg)
//           register-file side: read (get_reg_en/re/reg1/reg2/data_out*/
//           SREG_read) and write (we/reg_write_back/reg_write_code/data_in/
//           flag_update/SREG_write).
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter int WORD      = FMT_WORD,
    parameter int REGISTERS = FMT_REGISTERS,
    parameter int SREG_IDX  = FMT_SREG,
    parameter int WB_DEPTH  = 2,
    localparam int CODE_W   = $clog2(REGISTERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [CODE_W-1:0] dec_reg1,
    input  logic [CODE_W-1:0] dec_reg2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [WORD-1:0]   op_val1,
    output logic [WORD-1:0]   op_val2,
    output logic [WORD-1:0]   op_sreg,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [CODE_W-1:0] wb_code,
    input  logic [WORD-1:0]   wb_data,
    input  logic              wb_wr_reg,
    input  logic              wb_wr_flag,
    input  logic [WORD-1:0]   wb_sreg,
    output logic              get_reg_en,
    output logic [CODE_W-1:0] reg1,
    output logic [CODE_W-1:0] reg2,
    input  logic [WORD-1:0]   data_out1,
    input  logic [WORD-1:0]   data_out2,
    input  logic [WORD-1:0]   SREG_read,
    output logic              reg_write_back,
    output logic [CODE_W-1:0] reg_write_code,
    output logic [WORD-1:0]   data_in,
    output logic              flag_update,
    output logic [WORD-1:0]   SREG_write,
    output logic              re,
    output logic              we
);

    localparam int TAG_W   = CODE_W + FMT_WB_FLAGS;
    localparam int ENTRY_W = TAG_W + 2 * WORD;

    fetch_state_e        state_reg, state_next;
    logic [CODE_W-1:0]   reg1_reg, reg2_reg;
    logic [WORD-1:0]     op_val1_reg, op_val2_reg, op_sreg_reg;
    logic                dec_fire;
    logic                hazard;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [WB_DEPTH*TAG_W-1:0] fifo_tags;
    logic [WB_DEPTH-1:0] fifo_slot_valid;
    logic [WB_DEPTH-1:0] slot_hit;
    logic                in_hit;

    // SREG is read on every fetch, so a flag write always conflicts. A GPR
    // write to the SREG index is treated the same way since it aliases SREG.
    function automatic logic wb_conflict(input logic [CODE_W-1:0] code, input logic wr_reg,
                                         input logic wr_flag, input logic [CODE_W-1:0] r1,
                                         input logic [CODE_W-1:0] r2);
        return wr_flag || (wr_reg && (code == r1 || code == r2 || code == CODE_W'(SREG_IDX)));
    endfunction

    // ---------------- writeback buffer ----------------
    assign wb_ready  = !rst && !fifo_full;
    // Entries that write nothing are acknowledged but never stored.
    assign fifo_push = wb_valid && wb_ready && (wb_wr_reg || wb_wr_flag);
    assign fifo_pop  = !fifo_empty;

    wb_fifo #(
        .ENTRY_W(ENTRY_W),
        .TAG_W  (TAG_W),
        .DEPTH  (WB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({wb_code, wb_wr_reg, wb_wr_flag, wb_data, wb_sreg}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .slot_tags (fifo_tags),
        .slot_valid(fifo_slot_valid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Drain: the head drives the write port during the cycle it is popped.
    assign reg_write_back = fifo_pop && fifo_head[2*WORD+1];
    assign flag_update    = fifo_pop && fifo_head[2*WORD];
    assign reg_write_code = fifo_pop ? fifo_head[ENTRY_W-1 -: CODE_W] : '0;
    assign data_in        = fifo_pop ? fifo_head[2*WORD-1 -: WORD] : '0;
    assign SREG_write     = fifo_pop ? fifo_head[WORD-1:0] : '0;
    assign we             = reg_write_back || flag_update;

    // ---------------- hazard detect ----------------
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_hazard
        assign slot_hit[gi] = fifo_slot_valid[gi] &&
            wb_conflict(fifo_tags[gi*TAG_W+2 +: CODE_W], fifo_tags[gi*TAG_W+1],
                        fifo_tags[gi*TAG_W], dec_reg1, dec_reg2);
    end
    // An entry being pushed this cycle is not in the buffer yet but will be
    // by the time the fetch reads, so it counts as well.
    assign in_hit = fifo_push && wb_conflict(wb_code, wb_wr_reg, wb_wr_flag, dec_reg1, dec_reg2);
    assign hazard = (|slot_hit) || in_hit;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            reg1_reg    <= '0;
            reg2_reg    <= '0;
            op_val1_reg <= '0;
            op_val2_reg <= '0;
            op_sreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (dec_fire) begin
                reg1_reg <= dec_reg1;
                reg2_reg <= dec_reg2;
            end
            if (state_reg == ST_CAPT) begin
                op_val1_reg <= data_out1;
                op_val2_reg <= data_out2;
                op_sreg_reg <= SREG_read;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (dec_fire) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_CAPT;
            ST_CAPT:  state_next = ST_HOLD;
            ST_HOLD:  if (op_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dec_ready  = 1'b0;
        get_reg_en = 1'b0;
        reg1       = '0;
        reg2       = '0;
        op_valid   = 1'b0;
        case (state_reg)
            ST_IDLE:  dec_ready = !rst && !hazard;
            ST_FETCH: begin
                get_reg_en = 1'b1;
                reg1       = reg1_reg;
                reg2       = reg2_reg;
            end
            ST_HOLD:  op_valid = 1'b1;
            default:  ;
        endcase
    end

    assign dec_fire = dec_valid && dec_ready;
    assign re       = get_reg_en;
    assign op_val1  = op_val1_reg;
    assign op_val2  = op_val2_reg;
    assign op_sreg  = op_sreg_reg;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: register-file model, directed stimulus and a
// scoreboard of expected operand deliveries and register-file writes.
module tb_regfile_port_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid, dec_ready;
    logic [2:0]    dec_reg1, dec_reg2;
    logic          op_valid, op_ready;
    logic [W-1:0]  op_val1, op_val2, op_sreg;
    logic          wb_valid, wb_ready;
    logic [2:0]    wb_code;
    logic [W-1:0]  wb_data, wb_sreg;
    logic          wb_wr_reg, wb_wr_flag;
    logic          get_reg_en, re, we;
    logic [2:0]    reg1, reg2, reg_write_code;
    logic [W-1:0]  data_out1, data_out2, SREG_read, data_in, SREG_write;
    logic          reg_write_back, flag_update;

    always #5 clk = ~clk;

    regfile_port_ctrl #(
        .WORD(16), .REGISTERS(8), .SREG_IDX(7), .WB_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_reg1(dec_reg1), .dec_reg2(dec_reg2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_val1(op_val1), .op_val2(op_val2), .op_sreg(op_sreg),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_code(wb_code), .wb_data(wb_data), .wb_wr_reg(wb_wr_reg),
        .wb_wr_flag(wb_wr_flag), .wb_sreg(wb_sreg),
        .get_reg_en(get_reg_en), .reg1(reg1), .reg2(reg2),
        .data_out1(data_out1), .data_out2(data_out2), .SREG_read(SREG_read),
        .reg_write_back(reg_write_back), .reg_write_code(reg_write_code),
        .data_in(data_in), .flag_update(flag_update), .SREG_write(SREG_write),
        .re(re), .we(we)
    );

    // Register-file model: registered read on get_reg_en, write on we.
    logic [W-1:0] rf [8];
    logic [W-1:0] sreg_m;
    logic         preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            rf[2]  <= 16'h0012;
            rf[5]  <= 16'hFFF0;
            sreg_m <= 16'h0001;
        end else if (we) begin
            if (reg_write_back) rf[reg_write_code] <= data_in;
            if (flag_update)    sreg_m <= SREG_write;
        end
        if (get_reg_en) begin
            data_out1 <= rf[reg1];
            data_out2 <= rf[reg2];
            SREG_read <= sreg_m;
        end
    end

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int gre_cnt = 0;
    logic [47:0] op_q[$];
    logic [36:0] wb_q[$];
    logic [47:0] mon_op;
    logic [36:0] mon_wb;

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pulse counters plus scoreboard compares.
    always @(negedge clk) begin
        if (we) we_cnt++;
        if (get_reg_en) gre_cnt++;
        if (!rst && op_valid && op_ready) begin
            if (op_q.size() == 0) chk_eq("op_unexpected", 64'd1, 64'd0);
            else begin
                mon_op = op_q.pop_front();
                chk_eq("op_operands", {op_val1, op_val2, op_sreg}, mon_op);
                $display("TXN op   val1=%h val2=%h sreg=%h", op_val1, op_val2, op_sreg);
            end
        end
        if (!rst && we) begin
            if (wb_q.size() == 0) chk_eq("wb_unexpected", 64'd1, 64'd0);
            else begin
                mon_wb = wb_q.pop_front();
                chk_eq("wb_write", {reg_write_code, data_in, reg_write_back, flag_update, SREG_write}, mon_wb);
                $display("TXN wb   code=%0d data=%h wr=%b fl=%b sreg=%h",
                         reg_write_code, data_in, reg_write_back, flag_update, SREG_write);
            end
        end
    end

    task automatic push_wb(input logic [2:0] code, input logic [15:0] data, input logic wr,
                           input logic fl, input logic [15:0] s, input string nm);
        int n;
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_code = code; wb_data = data;
        wb_wr_reg = wr; wb_wr_flag = fl; wb_sreg = s;
        n = 0;
        @(negedge clk);
        while (!wb_ready && n < 20) begin n++; @(negedge clk); end
        chk_eq({nm, "_wb_ready"}, wb_ready, 1);
        if (wb_ready && (wr || fl)) wb_q.push_back({code, data, wr, fl, s});
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [2:0] r1, input logic [2:0] r2, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] es, input int exp_stall,
                            input int exp_we, input string nm);
        int n;
        @(posedge clk); #1;
        dec_valid = 1'b1; dec_reg1 = r1; dec_reg2 = r2;
        n = 0;
        @(negedge clk);
        while (!dec_ready && n < 40) begin n++; @(negedge clk); end
        chk_eq({nm, "_dec_ready"}, dec_ready, 1);
        if (!dec_ready) begin dec_valid = 1'b0; return; end
        chk_eq({nm, "_stall_cycles"}, n, exp_stall);
        if (exp_we >= 0) chk_eq({nm, "_drained_before_fetch"}, we_cnt, exp_we);
        op_q.push_back({e1, e2, es});
        @(posedge clk); #1;          // handshake edge
        dec_valid = 1'b0;
        @(negedge clk);              // cycle 1: FETCH
        chk_eq({nm, "_get_reg_en_c1"}, {get_reg_en, re, reg1, reg2}, {2'b11, r1, r2});
        @(negedge clk);              // cycle 2: CAPT
        chk_eq({nm, "_c2_quiet"}, {get_reg_en, op_valid}, 2'b00);
        @(negedge clk);              // cycle 3: HOLD
        chk_eq({nm, "_op_valid_c3"}, {op_valid, dec_ready}, 2'b10);
    endtask

    int w0, g0;

    initial begin
        rst = 1'b1; preload = 1'b1;
        dec_valid = 0; dec_reg1 = 0; dec_reg2 = 0; op_ready = 1'b1;
        wb_valid = 0; wb_code = 0; wb_data = 0; wb_wr_reg = 0; wb_wr_flag = 0; wb_sreg = 0;
        repeat (2) @(negedge clk);
        chk_eq("reset_outputs", {dec_ready, wb_ready, op_valid, get_reg_en, we, op_val1}, '0);
        @(posedge clk); #1;
        rst = 1'b0; preload = 1'b0;
        @(negedge clk);
        chk_eq("post_reset_ready", {dec_ready, wb_ready}, 2'b11);

        // Plain operand fetch
        do_fetch(3'd2, 3'd5, 16'h0012, 16'hFFF0, 16'h0001, 0, 0, "fetch");

        // RAW hazard on reg1
        fork
            push_wb(3'd3, 16'h00AA, 1'b1, 1'b0, 16'h0000, "raw");
            do_fetch(3'd3, 3'd2, 16'h00AA, 16'h0012, 16'h0001, 2, 1, "raw");
        join

        // Flag hazard
        fork
            push_wb(3'd0, 16'h0000, 1'b0, 1'b1, 16'h0004, "flag");
            do_fetch(3'd5, 3'd3, 16'hFFF0, 16'h00AA, 16'h0004, 2, 2, "flag");
        join

        // Dropped entry
        w0 = we_cnt;
        push_wb(3'd6, 16'h6666, 1'b0, 1'b0, 16'h1234, "drop");
        @(negedge clk);
        chk_eq("drop_count", 64'(dut.u_fifo.count_reg), 0);
        repeat (3) @(negedge clk);
        chk_eq("drop_no_we", we_cnt, w0);
        chk_eq("drop_dec_ready", dec_ready, 1);

        // FIFO full with the drain held off
        op_ready = 1'b0;
        force dut.fifo_pop = 1'b0;
        w0 = we_cnt;
        push_wb(3'd1, 16'h1111, 1'b1, 1'b0, 16'h0000, "full1");
        push_wb(3'd2, 16'h2222, 1'b1, 1'b0, 16'h0000, "full2");
        @(negedge clk);
        chk_eq("full_wb_ready", wb_ready, 0);
        chk_eq("full_count", 64'(dut.u_fifo.count_reg), 2);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_code = 3'd3; wb_data = 16'h3333; wb_wr_reg = 1'b1; wb_wr_flag = 1'b0;
        @(negedge clk);
        chk_eq("third_push_refused", wb_ready, 0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk_eq("full_count_kept", 64'(dut.u_fifo.count_reg), 2);
        chk_eq("full_no_drain", we_cnt, w0);
        @(posedge clk); #1;
        release dut.fifo_pop;
        op_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("full_drained_two", we_cnt, w0 + 2);
        chk_eq("full_empty_after", 64'(dut.u_fifo.count_reg), 0);

        // Back-to-back pushes wrapping the pointers
        w0 = we_cnt;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            wb_valid = 1'b1; wb_code = 3'(k); wb_data = 16'(16'h0101 * k);
            wb_wr_reg = 1'b1; wb_wr_flag = 1'b0; wb_sreg = 16'h0000;
            @(negedge clk);
            chk_eq("burst_wb_ready", wb_ready, 1);
            wb_q.push_back({3'(k), 16'(16'h0101 * k), 1'b1, 1'b0, 16'h0000});
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("burst_drained_five", we_cnt, w0 + 5);
        chk_eq("burst_empty_after", 64'(dut.u_fifo.count_reg), 0);

        // Reset in CAPT with one entry buffered
        @(posedge clk); #1;
        dec_valid = 1'b1; dec_reg1 = 3'd6; dec_reg2 = 3'd7;
        @(negedge clk);
        chk_eq("rst_mid_dec_ready", dec_ready, 1);
        @(posedge clk); #1;
        dec_valid = 1'b0;
        wb_valid = 1'b1; wb_code = 3'd1; wb_data = 16'h5555; wb_wr_reg = 1'b1; wb_wr_flag = 1'b0;
        @(negedge clk);
        chk_eq("rst_mid_fetch_and_wb", {get_reg_en, wb_ready}, 2'b11);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk_eq("rst_mid_buffered", 64'(dut.u_fifo.count_reg), 1);
        rst = 1'b1;
        w0 = we_cnt; g0 = gre_cnt;
        @(negedge clk);
        chk_eq("rst_mid_outputs", {op_valid, dec_ready, wb_ready, we, get_reg_en}, '0);
        chk_eq("rst_mid_fifo_empty", 64'(dut.u_fifo.count_reg), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_release_ready", {dec_ready, wb_ready, op_valid}, 3'b110);
        repeat (4) @(negedge clk);
        chk_eq("rst_no_write_pulse", we_cnt, w0);
        chk_eq("rst_no_fetch_pulse", gre_cnt, g0);
        chk_eq("rst_no_op_valid", op_valid, 0);

        // Fetch after reset sees the burst-written registers
        do_fetch(3'd4, 3'd5, 16'h0404, 16'h0505, 16'h0004, 0, -1, "post_rst");

        @(negedge clk);
        chk_eq("op_queue_empty", op_q.size(), 0);
        chk_eq("wb_queue_empty", wb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
